wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and a variable-latency unit (multi-cycle MDU/load-miss path) that returns results out of band. Sits between the writeback mux output and the register file write port. Buffers unit results in a small FIFO and steals port cycles when the pipeline writes nothing. Forces a one-cycle pipeline stall when a buffered result starves, the FIFO fills, or a destination register collides.

## Interface

Parameters:
- `BUF_DEPTH`, 2: unit-result FIFO entries (power of two, ≥2)
- `STARVE_MAX`, 4: consecutive denied cycles before a forced drain (≥1)

Ports:
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `pipe_we_i` in 1: pipeline writeback wants to write this cycle
- `pipe_rd_i` in 5: pipeline destination register
- `pipe_wdata_i` in XLEN: pipeline write-back value
- `pipe_stall_o` out 1: pipeline must hold its writeback instruction this cycle
- `lu_valid_i` in 1: unit result valid
- `lu_rd_i` in 5: unit destination register
- `lu_wdata_i` in XLEN: unit result
- `lu_ready_o` out 1: FIFO accepts a result this cycle
- `rf_we_o` out 1: register-file write enable (registered)
- `rf_waddr_o` out 5: register-file write address (registered)
- `rf_wdata_o` out XLEN: register-file write data (registered)
- `busy_o` out 1: FIFO non-empty

## Operation

- Enqueue occurs when `lu_valid_i && lu_ready_o`. `lu_ready_o = !full`, using registered full state. No enqueue while full, even if the same cycle dequeues.
- A pipeline write is effective when `pipe_we_i && pipe_rd_i != 0 && !pipe_stall_o`. Writes to x0 are never issued (`rf_we_o` stays 0). Unit results with rd = 0 are accepted and discarded on dequeue.
- States:
  - IDLE: FIFO empty.
  - PEND: FIFO non-empty, pipeline has priority.
  - FORCE: unit has priority.
- IDLE:
  - Pipeline write passes through.
  - → PEND on enqueue.
- PEND:
  - If there is no effective pipeline write, dequeue the head onto the port and clear the starve counter.
  - Otherwise, increment the starve counter.
  - → FORCE when the counter reaches `STARVE_MAX`, or when the FIFO is full at the end of the cycle.
  - → IDLE when the FIFO becomes empty.
- FORCE:
  - Drive `pipe_stall_o = 1`.
  - Dequeue exactly one head entry and clear the counter.
  - Next state is IDLE if the FIFO becomes empty, FORCE if it is still full, otherwise PEND.
- Collision: in any state, if the FIFO is non-empty, `pipe_we_i` is set, and `pipe_rd_i == head.rd != 0`, then:
  - `pipe_stall_o = 1` combinationally.
  - The head is dequeued that cycle.
  - The older unit result lands before the younger pipeline value.
- Simultaneous enqueue and dequeue keeps the count unchanged. Pointers wrap modulo `BUF_DEPTH`.
- Reset mid-operation discards all FIFO contents with no write issued. The unit must reissue.

## Timing

- Reset values: `rf_we_o = 0`, `rf_waddr_o = 0`, `rf_wdata_o = 0`, `pipe_stall_o = 0`, `lu_ready_o = 1`, `busy_o = 0`, state IDLE, counter 0.
- `pipe_stall_o` is combinational from state, FIFO head, `pipe_we_i` and `pipe_rd_i`. No path from `lu_*` inputs.
- `rf_*` outputs are registered: a grant in cycle N appears as a write in cycle N+1. `rf_we_o` drops the cycle after the last grant.
- Enqueue-to-write latency:
  - Minimum 2 cycles (enqueue at N, head grant at N+1, write at N+2).
  - Worst case `STARVE_MAX + 2` cycles when the FIFO holds one entry.
- One register-file write per cycle, maximum. Never two sources granted in the same cycle.

## Structure

- `riscv_pkg` gains:
  - `wb_arb_state_e` (IDLE, PEND, FORCE).
  - `wb_req_t` struct: `rd` [4:0] plus `wdata` [XLEN-1:0].
  - `XLEN` is reused from the package.
- Sub-module `wb_res_fifo`: parameterised sync FIFO of `wb_req_t` with `full`, `empty` and head peek. The arbiter holds only the FSM, starve counter and output register.

## Test plan

- Reset with `rst_ni = 0` → all outputs at reset values. Release, then pipeline writes x5 = 0x1234 → `rf_we_o = 1`, `rf_waddr_o = 5`, `rf_wdata_o = 0x1234` one cycle later, with `pipe_stall_o = 0`.
- Unit sends x7 = 0xAAAA while the pipeline is idle → write to x7 appears 2 cycles after enqueue. `busy_o` falls after the dequeue.
- Unit sends x7 and the pipeline writes x1..x6 every cycle with `STARVE_MAX = 4` → after 4 denied cycles, `pipe_stall_o = 1` for one cycle and x7 is written. The pipeline write held that cycle lands next.
- Unit sends 3 back-to-back results with `BUF_DEPTH = 2` under continuous pipeline writes → `lu_ready_o = 0` after 2 enqueues, then FORCE drains. The third result is accepted only after `lu_ready_o` returns to 1. No result is lost.
- Head x9 = 0x1 is buffered and the pipeline writes x9 = 0x2 in the same cycle → stall, write x9 = 0x1, then x9 = 0x2 next cycle. Final value is 0x2.
- Pipeline writes x0 and the unit sends x0 = 0xFFFF → `rf_we_o` never asserts. Assert `rst_ni` with 2 entries buffered → FIFO empties immediately and no write is issued after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types: datapath width, writeback arbiter state and the
// buffered writeback request carried through the unit-result FIFO.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // x0 is hardwired to zero; writes to it are never issued.
  localparam logic [4:0] REG_X0 = 5'd0;

  // IDLE: no buffered result. PEND: results buffered, pipeline wins the
  // port. FORCE: unit wins the port and the pipeline is stalled.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } wb_arb_state_e;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/wb_res_fifo.sv
// Small synchronous FIFO of writeback requests with head peek. Pointers
// wrap naturally because DEPTH is a power of two.
module wb_res_fifo
  import riscv_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  wb_req_t          push_data_i,
  input  logic             pop_i,
  output wb_req_t          head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; a push is refused while full.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  // Control state register; reset discards all buffered contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array written on accepted push.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; an empty count makes stale entries unreachable.
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order writeback stage
// and an out-of-band variable-latency unit. Unit results are buffered and
// drained into idle pipeline slots; starvation, a full buffer or a
// destination collision stall the pipeline for a cycle to force a drain.
module wb_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned BUF_DEPTH  = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            pipe_we_i,
  input  logic [4:0]      pipe_rd_i,
  input  logic [XLEN-1:0] pipe_wdata_i,
  output logic            pipe_stall_o,
  input  logic            lu_valid_i,
  input  logic [4:0]      lu_rd_i,
  input  logic [XLEN-1:0] lu_wdata_i,
  output logic            lu_ready_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            busy_o
);

  localparam int unsigned CNT_W    = ((BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1) + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  wb_arb_state_e         state_q, state_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  rf_we_q, rf_we_d;
  logic [4:0]            rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;

  wb_req_t               head;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count, count_nxt;
  logic                  enq, deq, collision, stall, pipe_fire;

  assign enq          = lu_valid_i && !fifo_full;
  assign lu_ready_o   = !fifo_full;
  assign busy_o       = !fifo_empty;
  assign pipe_stall_o = stall;
  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;

  wb_res_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (enq),
    .push_data_i ('{rd: lu_rd_i, wdata: lu_wdata_i}),
    .pop_i       (deq),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Port grant: stall decision, which source owns the port, and the write it issues.
  always_comb begin
    collision = !fifo_empty && pipe_we_i && (pipe_rd_i == head.rd) && (head.rd != REG_X0);
    stall     = (state_q == FORCE) || collision;
    pipe_fire = pipe_we_i && (pipe_rd_i != REG_X0) && !stall;

    deq = 1'b0;
    unique case (state_q)
      PEND:    deq = !pipe_fire;
      FORCE:   deq = 1'b1;
      default: deq = 1'b0;
    endcase
    // An older buffered result to the same register must land first.
    if (collision) deq = 1'b1;
    deq = deq && !fifo_empty;

    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_fire) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_rd_i;
      rf_wdata_d = pipe_wdata_i;
    end else if (deq && (head.rd != REG_X0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head.rd;
      rf_wdata_d = head.wdata;
    end
  end

  // FSM next state and starve counter, based on occupancy at end of cycle.
  always_comb begin
    count_nxt = fifo_count + CNT_W'(enq) - CNT_W'(deq);
    state_d   = state_q;
    starve_d  = starve_q;
    unique case (state_q)
      IDLE: begin
        starve_d = '0;
        if (count_nxt != '0) state_d = PEND;
      end
      PEND: begin
        if (deq)            starve_d = '0;
        else if (pipe_fire) starve_d = starve_q + STARVE_W'(1);
        if (count_nxt == '0)
          state_d = IDLE;
        else if ((starve_d == STARVE_W'(STARVE_MAX)) || (count_nxt == CNT_W'(BUF_DEPTH)))
          state_d = FORCE;
      end
      FORCE: begin
        starve_d = '0;
        if (count_nxt == '0)                     state_d = IDLE;
        else if (count_nxt == CNT_W'(BUF_DEPTH)) state_d = FORCE;
        else                                     state_d = PEND;
      end
      default: begin
        state_d  = IDLE;
        starve_d = '0;
      end
    endcase
  end

  // FSM, starve counter and registered register-file write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (BUF_DEPTH=2, STARVE_MAX=4). Each table
// row is one cycle: inputs, expected combinational outputs before the edge
// and the expected register-file write visible after it.
module tb_wb_port_arbiter;
  import riscv_pkg::*;

  logic            clk_i, rst_ni;
  logic            pipe_we_i;
  logic [4:0]      pipe_rd_i;
  logic [XLEN-1:0] pipe_wdata_i;
  logic            pipe_stall_o;
  logic            lu_valid_i;
  logic [4:0]      lu_rd_i;
  logic [XLEN-1:0] lu_wdata_i;
  logic            lu_ready_o;
  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;
  logic            busy_o;

  int n_checks = 0;
  int n_errors = 0;

  wb_port_arbiter #(.BUF_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pipe_we_i    (pipe_we_i),
    .pipe_rd_i    (pipe_rd_i),
    .pipe_wdata_i (pipe_wdata_i),
    .pipe_stall_o (pipe_stall_o),
    .lu_valid_i   (lu_valid_i),
    .lu_rd_i      (lu_rd_i),
    .lu_wdata_i   (lu_wdata_i),
    .lu_ready_o   (lu_ready_o),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .busy_o       (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic            pwe;
    logic [4:0]      prd;
    logic [XLEN-1:0] pdat;
    logic            lv;
    logic [4:0]      lrd;
    logic [XLEN-1:0] ldat;
    logic            stall;
    logic            ready;
    logic            busy;
    logic            we;
    logic [4:0]      wa;
    logic [XLEN-1:0] wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic pwe, logic [4:0] prd, logic [XLEN-1:0] pdat,
                              logic lv, logic [4:0] lrd, logic [XLEN-1:0] ldat,
                              logic stall, logic ready, logic busy,
                              logic we, logic [4:0] wa, logic [XLEN-1:0] wd);
    vec_t r;
    r.pwe = pwe; r.prd = prd; r.pdat = pdat;
    r.lv = lv; r.lrd = lrd; r.ldat = ldat;
    r.stall = stall; r.ready = ready; r.busy = busy;
    r.we = we; r.wa = wa; r.wd = wd;
    return r;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [XLEN-1:0] pdat,
                       input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldat);
    pipe_we_i = pwe; pipe_rd_i = prd; pipe_wdata_i = pdat;
    lu_valid_i = lv; lu_rd_i = lrd; lu_wdata_i = ldat;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rf_we"},    XLEN'(rf_we_o),      '0);
    check({tag, " rf_waddr"}, XLEN'(rf_waddr_o),   '0);
    check({tag, " rf_wdata"}, rf_wdata_o,          '0);
    check({tag, " stall"},    XLEN'(pipe_stall_o), '0);
    check({tag, " ready"},    XLEN'(lu_ready_o),   XLEN'(1));
    check({tag, " busy"},     XLEN'(busy_o),       '0);
  endtask

  initial begin
    // Columns: pipe we/rd/data, unit valid/rd/data, exp stall/ready/busy, exp rf we/addr/data.
    // Plain pipeline write passes through.
    vecs.push_back(mk(1, 5, 'h1234, 0, 0, 0,      0, 1, 0, 1, 5, 'h1234));
    vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0, 1, 0, 0, 0, 0));
    // Unit result into an idle pipeline: written two cycles after enqueue.
    vecs.push_back(mk(0, 0, 0,      1, 7, 'hAAAA, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0, 1, 1, 1, 7, 'hAAAA));
    vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0, 1, 0, 0, 0, 0));
    // Starvation: four denied cycles, then a forced drain with the x6 write held.
    vecs.push_back(mk(1, 1, 'h11,   1, 7, 'h7777, 0, 1, 0, 1, 1, 'h11));
    vecs.push_back(mk(1, 2, 'h22,   0, 0, 0,      0, 1, 1, 1, 2, 'h22));
    vecs.push_back(mk(1, 3, 'h33,   0, 0, 0,      0, 1, 1, 1, 3, 'h33));
    vecs.push_back(mk(1, 4, 'h44,   0, 0, 0,      0, 1, 1, 1, 4, 'h44));
    vecs.push_back(mk(1, 5, 'h55,   0, 0, 0,      0, 1, 1, 1, 5, 'h55));
    vecs.push_back(mk(1, 6, 'h66,   0, 0, 0,      1, 1, 1, 1, 7, 'h7777));
    vecs.push_back(mk(1, 6, 'h66,   0, 0, 0,      0, 1, 0, 1, 6, 'h66));
    vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0, 1, 0, 0, 0, 0));
    // Three back-to-back results into a two-entry buffer under continuous writes.
    vecs.push_back(mk(1, 1, 'h101,  1, 10, 'hA0,  0, 1, 0, 1, 1, 'h101));
    vecs.push_back(mk(1, 2, 'h102,  1, 11, 'hA1,  0, 1, 1, 1, 2, 'h102));
    vecs.push_back(mk(1, 3, 'h103,  1, 12, 'hA2,  1, 0, 1, 1, 10, 'hA0));
    vecs.push_back(mk(1, 3, 'h103,  1, 12, 'hA2,  0, 1, 1, 1, 3, 'h103));
    vecs.push_back(mk(1, 4, 'h104,  0, 0, 0,      1, 0, 1, 1, 11, 'hA1));
    vecs.push_back(mk(1, 4, 'h104,  0, 0, 0,      0, 1, 1, 1, 4, 'h104));
    vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0, 1, 1, 1, 12, 'hA2));
    vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0, 1, 0, 0, 0, 0));
    // Destination collision: older unit x9=1 lands before pipeline x9=2.
    vecs.push_back(mk(0, 0, 0,      1, 9, 'h1,    0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 9, 'h2,    0, 0, 0,      1, 1, 1, 1, 9, 'h1));
    vecs.push_back(mk(1, 9, 'h2,    0, 0, 0,      0, 1, 0, 1, 9, 'h2));
    vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0, 1, 0, 0, 0, 0));
    // Writes to x0 from either source never reach the port.
    vecs.push_back(mk(1, 0, 'h5555, 1, 0, 'hFFFF, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 'h5555, 0, 0, 0,      0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0, 1, 0, 0, 0, 0));

    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      drive(vecs[i].pwe, vecs[i].prd, vecs[i].pdat, vecs[i].lv, vecs[i].lrd, vecs[i].ldat);
      #1;
      check($sformatf("row%0d stall", i), XLEN'(pipe_stall_o), XLEN'(vecs[i].stall));
      check($sformatf("row%0d ready", i), XLEN'(lu_ready_o),   XLEN'(vecs[i].ready));
      check($sformatf("row%0d busy", i),  XLEN'(busy_o),       XLEN'(vecs[i].busy));
      @(posedge clk_i);
      #1;
      check($sformatf("row%0d rf_we", i), XLEN'(rf_we_o), XLEN'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("row%0d rf_waddr", i), XLEN'(rf_waddr_o), XLEN'(vecs[i].wa));
        check($sformatf("row%0d rf_wdata", i), rf_wdata_o,        vecs[i].wd);
      end
    end

    // Reset with two results buffered: everything is discarded, no write follows.
    @(negedge clk_i);
    drive(1, 1, 'h201, 1, 13, 'hB0);
    @(negedge clk_i);
    drive(1, 2, 'h202, 1, 14, 'hB1);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("midrst pre busy",  XLEN'(busy_o),     XLEN'(1));
    check("midrst pre ready", XLEN'(lu_ready_o), '0);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i);
      #1;
      check($sformatf("post_rst%0d rf_we", c), XLEN'(rf_we_o), '0);
      check($sformatf("post_rst%0d busy", c),  XLEN'(busy_o),  '0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
